fft_spectrum_sink: RTL and testbench

AXI4-Stream receiver for the FFT core's output stream. It consumes one complex result per beat and computes an approximate magnitude. Magnitudes go into a ping-pong spectrum buffer, and a random-access read port serves the display/readout logic. It sits on fft_clk directly downstream of the FFT core's o_axi4s_data_* outputs and is the consumer counterpart of the sample feeder in the oscilloscope top.

---
 rtl/fft_spectrum_sink.sv | 207 ++++++++++++++++++++
 tb/tb_fft_spectrum_sink.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_spectrum_sink.sv
// AXI4-Stream sink for FFT results: approximate magnitude into a ping-pong spectrum buffer.
// Optional peak tracking is compiled in with FFT_PEAK_DETECT_EN.
module fft_spectrum_sink #(
  parameter int N_POINTS = 256,
  parameter int ADDR_W   = 8
) (
  input  logic              fft_clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              s_tvalid,
  input  logic [31:0]       s_tdata,
  input  logic              s_tlast,
  input  logic [ADDR_W-1:0] s_tuser,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data,
  output logic              spectrum_valid,
  output logic              bank_sel,
  output logic              frame_done,
  output logic              frame_err,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       peak_mag,
  output logic [ADDR_W-1:0] peak_bin
);

  typedef enum logic [1:0] {IDLE, CAPTURE, SWAP, RESYNC} state_t;

  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(N_POINTS - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] wcnt, wcnt_nx;
  logic              acc, err_c, good_c;
  logic [ADDR_W-1:0] acc_addr;
  logic              swap_pend, swap_fire;
  logic [1:0]        swap_cnt;

  logic              s1_v, s1_bank;
  logic [15:0]       s1_re, s1_im;
  logic [ADDR_W-1:0] s1_addr;
  logic              s2_v, s2_bank;
  logic [15:0]       s2_mag;
  logic [ADDR_W-1:0] s2_addr;
  logic [15:0]       mx, mn;

  logic [15:0] mem [0:2*N_POINTS-1];

  function automatic logic [15:0] abs16(input logic [15:0] v);
    return v[15] ? (~v + 16'd1) : v;
  endfunction

  always_ff @(posedge fft_clk) begin
    if (!rst_n) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
    end
  end

  // SWAP shares IDLE's beat handling; the bank swap itself is tracked by swap_pend.
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    acc      = 1'b0;
    acc_addr = wcnt;
    err_c    = 1'b0;
    good_c   = 1'b0;
    case (state)
      IDLE, SWAP: begin
        if (state == SWAP && swap_fire) state_nx = IDLE;
        if (s_tvalid && arm) begin
          if (s_tuser != '0) begin
            state_nx = RESYNC;
          end else if (s_tlast) begin
            err_c = 1'b1;
          end else begin
            acc      = 1'b1;
            acc_addr = '0;
            wcnt_nx  = ADDR_W'(1);
            state_nx = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (s_tvalid) begin
          acc     = 1'b1;
          wcnt_nx = wcnt + ADDR_W'(1);
          if (s_tuser != wcnt) begin
            err_c    = 1'b1;
            wcnt_nx  = '0;
            state_nx = s_tlast ? IDLE : RESYNC;
          end else if (s_tlast && wcnt != LAST_BIN) begin
            err_c    = 1'b1;
            wcnt_nx  = '0;
            state_nx = IDLE;
          end else if (!s_tlast && wcnt == LAST_BIN) begin
            err_c    = 1'b1;
            wcnt_nx  = '0;
            state_nx = RESYNC;
          end else if (s_tlast) begin
            good_c   = 1'b1;
            wcnt_nx  = '0;
            state_nx = SWAP;
          end
        end
      end
      RESYNC: begin
        if (s_tvalid && s_tlast) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Last write lands two edges after the tlast beat; the swap follows on the third.
  assign swap_fire = swap_pend && (swap_cnt == 2'd0);

  always_ff @(posedge fft_clk) begin
    if (!rst_n) begin
      swap_pend      <= 1'b0;
      swap_cnt       <= '0;
      bank_sel       <= 1'b0;
      frame_done     <= 1'b0;
      frame_err      <= 1'b0;
      frame_cnt      <= '0;
      spectrum_valid <= 1'b0;
    end else begin
      frame_done <= swap_fire;
      frame_err  <= err_c;
      if (good_c) begin
        swap_pend <= 1'b1;
        swap_cnt  <= 2'd2;
      end else if (swap_fire) begin
        swap_pend      <= 1'b0;
        bank_sel       <= ~bank_sel;
        frame_cnt      <= frame_cnt + 16'd1;
        spectrum_valid <= 1'b1;
      end else if (swap_pend) begin
        swap_cnt <= swap_cnt - 2'd1;
      end
    end
  end

  assign mx = (s1_re >= s1_im) ? s1_re : s1_im;
  assign mn = (s1_re >= s1_im) ? s1_im : s1_re;

  // Beats accepted while a swap is pending target the bank that becomes the back bank.
  always_ff @(posedge fft_clk) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_bank <= 1'b0;
      s1_re   <= '0;
      s1_im   <= '0;
      s1_addr <= '0;
      s2_v    <= 1'b0;
      s2_bank <= 1'b0;
      s2_mag  <= '0;
      s2_addr <= '0;
    end else begin
      s1_v    <= acc;
      s1_bank <= swap_pend ? bank_sel : ~bank_sel;
      s1_re   <= abs16(s_tdata[15:0]);
      s1_im   <= abs16(s_tdata[31:16]);
      s1_addr <= acc_addr;
      s2_v    <= s1_v;
      s2_bank <= s1_bank;
      s2_mag  <= mx + (mn >> 1);
      s2_addr <= s1_addr;
    end
  end

  always_ff @(posedge fft_clk) begin
    if (s2_v) mem[{s2_bank, s2_addr}] <= s2_mag;
  end

  always_ff @(posedge fft_clk) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[{bank_sel, rd_addr}];
  end

`ifdef FFT_PEAK_DETECT_EN
  logic [15:0]       run_mag;
  logic [ADDR_W-1:0] run_bin;

  // Bin 1 seeds the running peak; strict compare keeps the lowest index on ties.
  always_ff @(posedge fft_clk) begin
    if (!rst_n) begin
      run_mag  <= '0;
      run_bin  <= '0;
      peak_mag <= '0;
      peak_bin <= '0;
    end else begin
      if (s2_v && s2_addr != '0 && (s2_addr == ADDR_W'(1) || s2_mag > run_mag)) begin
        run_mag <= s2_mag;
        run_bin <= s2_addr;
      end
      if (swap_fire) begin
        peak_mag <= run_mag;
        peak_bin <= run_bin;
      end
    end
  end
`else
  assign peak_mag = '0;
  assign peak_bin = '0;
`endif

endmodule

// File: tb/tb_fft_spectrum_sink.sv
// Directed, table-driven bench for fft_spectrum_sink (peak checks follow FFT_PEAK_DETECT_EN).
module tb_fft_spectrum_sink;
  localparam int N  = 256;
  localparam int AW = 8;
`ifdef FFT_PEAK_DETECT_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  logic          fft_clk = 1'b0;
  logic          rst_n, arm, s_tvalid, s_tlast;
  logic [31:0]   s_tdata;
  logic [AW-1:0] s_tuser, rd_addr, peak_bin;
  logic [15:0]   rd_data, frame_cnt, peak_mag;
  logic          spectrum_valid, bank_sel, frame_done, frame_err;

  fft_spectrum_sink #(.N_POINTS(N), .ADDR_W(AW)) dut (
    .fft_clk(fft_clk), .rst_n(rst_n), .arm(arm), .s_tvalid(s_tvalid),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tuser(s_tuser), .rd_addr(rd_addr),
    .rd_data(rd_data), .spectrum_valid(spectrum_valid), .bank_sel(bank_sel),
    .frame_done(frame_done), .frame_err(frame_err), .frame_cnt(frame_cnt),
    .peak_mag(peak_mag), .peak_bin(peak_bin)
  );

  always #5 fft_clk = ~fft_clk;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [15:0] mag;
  } vec_t;
  vec_t tbl[12];

  logic [15:0] fre[N];
  logic [15:0] fim[N];

  int checks = 0, failures = 0;
  int cyc = 0, done_n = 0, err_n = 0, done_cyc = -1, last_cyc = 0;
  int d0, e0, toggles;
  bit stop, prev_bs;

  always @(posedge fft_clk) cyc <= cyc + 1;
  always @(negedge fft_clk) begin
    if (frame_done) begin done_n++; done_cyc = cyc; end
    if (frame_err) err_n++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic beat(input int user, input bit last);
    s_tvalid = 1'b1;
    s_tdata  = {fim[user % N], fre[user % N]};
    s_tuser  = AW'(user % N);
    s_tlast  = last;
    @(posedge fft_clk); #1;
    if (last) last_cyc = cyc;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send(input int first, input int nbeats, input int last_idx);
    for (int i = 0; i < nbeats; i++) beat(first + i, i == last_idx);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge fft_clk);
    #1;
  endtask

  task automatic read_chk(input string name, input int a, input logic [15:0] exp);
    rd_addr = AW'(a);
    @(posedge fft_clk); #1;
    check(name, rd_data, exp);
  endtask

  task automatic fill(input logic [15:0] re, input logic [15:0] im);
    for (int i = 0; i < N; i++) begin fre[i] = re; fim[i] = im; end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_valid"}, spectrum_valid, 0);
    check({tag, "_bank_sel"}, bank_sel, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_err"}, frame_err, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
    check({tag, "_peak_mag"}, peak_mag, 0);
    check({tag, "_peak_bin"}, peak_bin, 0);
  endtask

  initial begin
    tbl[0]  = '{16'd3,      16'hFFFC, 16'd5};
    tbl[1]  = '{16'd0,      16'd0,    16'd0};
    tbl[2]  = '{16'h8000,   16'd0,    16'd32768};
    tbl[3]  = '{16'h7FFF,   16'h7FFF, 16'd49150};
    tbl[4]  = '{16'hFFFF,   16'd1,    16'd1};
    tbl[5]  = '{16'd100,    16'hFED4, 16'd350};
    tbl[6]  = '{16'hFFF9,   16'd2,    16'd8};
    tbl[7]  = '{16'h8000,   16'h8000, 16'd49152};
    tbl[8]  = '{16'd1000,   16'd0,    16'd1000};
    tbl[9]  = '{16'd0,      16'hFFFB, 16'd5};
    tbl[10] = '{16'hFFFD,   16'hFFFD, 16'd4};
    tbl[11] = '{16'd32000,  16'd16000, 16'd40000};

    rst_n = 1'b0; arm = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tdata = '0; s_tuser = '0; rd_addr = '0;
    fill(16'd0, 16'd0);
    idle(3);
    chk_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Clean frame, re=3 im=-4 everywhere
    fill(16'd3, 16'hFFFC);
    arm = 1'b1;
    d0 = done_n;
    send(0, N, N - 1);
    idle(6);
    check("A_done_count", done_n - d0, 1);
    check("A_done_latency", done_cyc - last_cyc, 3);
    check("A_bank_sel", bank_sel, 1);
    check("A_frame_cnt", frame_cnt, 1);
    check("A_valid", spectrum_valid, 1);
    check("A_peak_mag", peak_mag, PEAK_EN ? 5 : 0);
    check("A_peak_bin", peak_bin, PEAK_EN ? 1 : 0);
    for (int a = 0; a < N; a++) read_chk("A_rd", a, 16'd5);

    // Table-driven frame: bin i carries tbl[i % 12]
    for (int i = 0; i < N; i++) begin fre[i] = tbl[i % 12].re; fim[i] = tbl[i % 12].im; end
    send(0, N, N - 1);
    idle(6);
    check("B_bank_sel", bank_sel, 0);
    check("B_frame_cnt", frame_cnt, 2);
    check("B_peak_mag", peak_mag, PEAK_EN ? 49152 : 0);
    check("B_peak_bin", peak_bin, PEAK_EN ? 7 : 0);
    for (int a = 0; a < N; a++) read_chk("B_rd", a, tbl[a % 12].mag);

    // Early tlast on beat 100
    fill(16'd9, 16'd0);
    d0 = done_n; e0 = err_n;
    send(0, 101, 100);
    idle(6);
    check("C_err_count", err_n - e0, 1);
    check("C_done_count", done_n - d0, 0);
    check("C_bank_sel", bank_sel, 0);
    check("C_frame_cnt", frame_cnt, 2);
    check("C_peak_mag", peak_mag, PEAK_EN ? 49152 : 0);
    read_chk("C_rd10", 10, tbl[10].mag);
    read_chk("C_rd100", 100, tbl[4].mag);

    // Full length without tlast, then a tlast beat to resync
    e0 = err_n;
    send(0, N, -1);
    beat(0, 1'b1);
    idle(6);
    check("D_err_count", err_n - e0, 1);
    check("D_done_count", done_n - d0, 0);
    check("D_bank_sel", bank_sel, 0);

    // Arm raised mid-stream at tuser=50
    arm = 1'b0;
    e0 = err_n;
    send(0, 50, -1);
    arm = 1'b1;
    send(50, N - 50, N - 51);
    idle(4);
    check("E_err_count", err_n - e0, 0);
    check("E_done_count", done_n - d0, 0);

    // Peak pattern frame, with address 10 read every cycle across the swap
    fill(16'd0, 16'd0);
    fre[0] = 16'd32000; fim[0] = 16'd16000;
    fre[20] = 16'd1000; fre[30] = 16'd1000;
    rd_addr = AW'(10);
    idle(1);
    stop = 1'b0; toggles = 0; prev_bs = bank_sel;
    fork
      begin
        send(0, N, N - 1);
        idle(6);
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge fft_clk); #2;
          check("F_rd10_swap", rd_data, prev_bs ? 0 : 4);
          if (bank_sel != prev_bs) toggles++;
          prev_bs = bank_sel;
        end
      end
    join
    check("F_toggles", toggles, 1);
    check("F_done_count", done_n - d0, 1);
    check("F_bank_sel", bank_sel, 1);
    check("F_frame_cnt", frame_cnt, 3);
    check("F_peak_mag", peak_mag, PEAK_EN ? 1000 : 0);
    check("F_peak_bin", peak_bin, PEAK_EN ? 20 : 0);
    read_chk("F_rd0", 0, 16'd40000);
    read_chk("F_rd20", 20, 16'd1000);
    read_chk("F_rd30", 30, 16'd1000);
    read_chk("F_rd255", 255, 16'd0);

    // Reset in the middle of a frame
    send(0, 50, -1);
    rst_n = 1'b0;
    idle(1);
    chk_zero("midreset");
    rst_n = 1'b1;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
